// File: rtl/mem_wb_stage.sv
// RV64 memory-access stage plus MEM/WB pipeline register: valid/ready data-memory
// bus, load/store lane formatting, upstream stall and writeback result select.
module mem_wb_stage #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [XLEN-1:0] ExtImmM,
   input  logic [4:0]      RdM,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic [2:0]      Funct3M,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_wstrb,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            StallM,
   output logic [XLEN-1:0] ResultW,
   output logic [4:0]      RdW,
   output logic            RegWriteW,
   output logic            MisalignW
);

   typedef enum logic [1:0] {IDLE, WAIT_RSP, DONE} state_t;

   state_t          state, state_next;
   logic            memop;
   logic            misaligned;
   logic [2:0]      lane;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_fmt;
   logic [XLEN-1:0] load_hold;
   logic [XLEN-1:0] result_sel;
   logic            mis_pending;

   assign lane      = ALUResultM[2:0];
   assign memop     = MemWriteM | (ResultSrcM == 2'b01);
   assign dmem_we   = MemWriteM;
   assign dmem_addr = {ALUResultM[XLEN-1:3], 3'b000};

   always_comb begin
      misaligned = 1'b0;
      case (Funct3M[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = lane[0];
         2'b10:   misaligned = |lane[1:0];
         default: misaligned = |lane;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (memop) begin
               if (misaligned)          state_next = DONE;
               else if (dmem_req_ready) state_next = MemWriteM ? DONE : WAIT_RSP;
            end
         end
         WAIT_RSP: if (dmem_rsp_valid) state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Reset also masks the request/stall so a held memory op cannot leak onto the bus.
   always_comb begin
      dmem_req_valid = 1'b0;
      StallM         = 1'b0;
      case (state)
         IDLE: begin
            StallM         = memop;
            dmem_req_valid = memop & ~misaligned;
         end
         WAIT_RSP: StallM = 1'b1;
         default: ;
      endcase
      if (!rst) begin
         dmem_req_valid = 1'b0;
         StallM         = 1'b0;
      end
   end

   always_comb begin
      dmem_wdata = WriteDataM;
      dmem_wstrb = 8'hFF;
      case (Funct3M[1:0])
         2'b00: begin
            dmem_wdata = {8{WriteDataM[7:0]}};
            dmem_wstrb = 8'h01 << lane;
         end
         2'b01: begin
            dmem_wdata = {4{WriteDataM[15:0]}};
            dmem_wstrb = 8'h03 << lane;
         end
         2'b10: begin
            dmem_wdata = {2{WriteDataM[31:0]}};
            dmem_wstrb = 8'h0F << lane;
         end
         default: begin
            dmem_wdata = WriteDataM;
            dmem_wstrb = 8'hFF;
         end
      endcase
   end

   assign shifted = dmem_rdata >> {lane, 3'b000};

   always_comb begin
      load_fmt = shifted;
      case (Funct3M)
         3'b000:  load_fmt = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_fmt = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b010:  load_fmt = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         3'b100:  load_fmt = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  load_fmt = {{(XLEN-16){1'b0}}, shifted[15:0]};
         3'b110:  load_fmt = {{(XLEN-32){1'b0}}, shifted[31:0]};
         default: load_fmt = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                     load_hold <= '0;
      else if ((state == WAIT_RSP) && dmem_rsp_valid) load_hold <= load_fmt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               mis_pending <= 1'b0;
      else if (state == IDLE) mis_pending <= memop & misaligned;
   end

   always_comb begin
      case (ResultSrcM)
         2'b00:   result_sel = ALUResultM;
         2'b01:   result_sel = load_hold;
         2'b10:   result_sel = PCPlus4M;
         default: result_sel = ExtImmM;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ResultW   <= '0;
         RdW       <= '0;
         RegWriteW <= 1'b0;
         MisalignW <= 1'b0;
      end else if (!StallM) begin
         ResultW   <= result_sel;
         RdW       <= RdM;
         RegWriteW <= RegWriteM & ~((state == DONE) & mis_pending);
         MisalignW <= (state == DONE) & mis_pending;
      end else begin
         RegWriteW <= 1'b0;
         MisalignW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

   logic        clk, rst;
   logic [63:0] ALUResultM, WriteDataM, PCPlus4M, ExtImmM;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_rsp_valid;
   logic [63:0] dmem_rdata;
   logic        StallM;
   logic [63:0] ResultW;
   logic [4:0]  RdW;
   logic        RegWriteW, MisalignW;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  src;
      logic [63:0] alu, pc4, imm;
      logic [4:0]  rd;
      logic        rw;
      logic [63:0] exp_res;
   } alu_vec_t;

   typedef struct {
      logic        st;
      logic [63:0] addr;
      logic [2:0]  f3;
      logic [63:0] wd, rdata;
      int          ready_dly, rsp_dly;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_wstrb;
      logic [63:0] exp_res;
      logic        exp_rw, exp_mis;
      int          exp_stall, exp_req;
   } mem_vec_t;

   alu_vec_t    av[4];
   mem_vec_t    mv[17];

   logic        log_en = 1'b0;
   int          wn = 0;
   logic [63:0] wlog[8];
   logic [4:0]  wrd[8];

   mem_wb_stage #(.XLEN(64)) dut (
      .clk(clk), .rst(rst),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .ExtImmM(ExtImmM),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .StallM(StallM), .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .MisalignW(MisalignW)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // Each retired write appears on RegWriteW for exactly one cycle.
   always @(negedge clk) begin
      if (log_en && RegWriteW && wn < 8) begin
         wlog[wn] = ResultW;
         wrd[wn]  = RdW;
         wn++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_nop();
      ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; ExtImmM = '0;
      RdM = '0; RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; Funct3M = 3'b000;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
   endtask

   task automatic run_alu(input int idx, input alu_vec_t v);
      ResultSrcM = v.src; ALUResultM = v.alu; PCPlus4M = v.pc4; ExtImmM = v.imm;
      RdM = v.rd; RegWriteM = v.rw; MemWriteM = 1'b0; Funct3M = 3'b011;
      @(negedge clk);
      check($sformatf("alu%0d_stall", idx), StallM, 0);
      check($sformatf("alu%0d_req", idx), dmem_req_valid, 0);
      @(posedge clk); #1;
      check($sformatf("alu%0d_result", idx), ResultW, v.exp_res);
      check($sformatf("alu%0d_rd", idx), RdW, v.rd);
      check($sformatf("alu%0d_regwrite", idx), RegWriteW, v.rw);
      check($sformatf("alu%0d_misalign", idx), MisalignW, 0);
   endtask

   task automatic run_mem(input int idx, input mem_vec_t v);
      int   stall_n, req_n, wcnt, bad_req, bad_bub;
      bit   accepted, done;
      logic [4:0] rd;
      stall_n = 0; req_n = 0; wcnt = 0; bad_req = 0; bad_bub = 0;
      accepted = 1'b0; done = 1'b0;
      rd = 5'(idx + 8);
      ALUResultM = v.addr; WriteDataM = v.wd; PCPlus4M = 64'hDEAD_0004; ExtImmM = 64'hDEAD_1111;
      RdM = rd; MemWriteM = v.st; RegWriteM = ~v.st; ResultSrcM = v.st ? 2'b00 : 2'b01;
      Funct3M = v.f3; dmem_rdata = v.rdata;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         dmem_rsp_valid = 1'b0;
         dmem_req_ready = 1'b0;
         if (!StallM) done = 1'b1;
         else begin
            stall_n++;
            if (stall_n > 1 && RegWriteW) bad_bub++;
            if (dmem_req_valid) begin
               req_n++;
               if (dmem_addr !== {v.addr[63:3], 3'b000} || dmem_we !== v.st ||
                   (v.st && (dmem_wdata !== v.exp_wdata || dmem_wstrb !== v.exp_wstrb)))
                  bad_req++;
               if (req_n > v.ready_dly) begin
                  dmem_req_ready = 1'b1;
                  accepted = 1'b1;
               end
            end else if (accepted) begin
               if (wcnt == v.rsp_dly) dmem_rsp_valid = 1'b1;
               wcnt++;
            end
         end
      end
      check($sformatf("mem%0d_finished", idx), done, 1);
      check($sformatf("mem%0d_stall_cycles", idx), 64'(stall_n), 64'(v.exp_stall));
      check($sformatf("mem%0d_req_cycles", idx), 64'(req_n), 64'(v.exp_req));
      check($sformatf("mem%0d_req_fields_bad", idx), 64'(bad_req), 0);
      check($sformatf("mem%0d_bubble_bad", idx), 64'(bad_bub), 0);
      @(posedge clk); #1;
      check($sformatf("mem%0d_rd", idx), RdW, rd);
      check($sformatf("mem%0d_regwrite", idx), RegWriteW, v.exp_rw);
      check($sformatf("mem%0d_misalign", idx), MisalignW, v.exp_mis);
      if (v.exp_rw) check($sformatf("mem%0d_result", idx), ResultW, v.exp_res);
      set_nop();
      @(posedge clk); #1;
      check($sformatf("mem%0d_misalign_drop", idx), MisalignW, 0);
      check($sformatf("mem%0d_nop_regwrite", idx), RegWriteW, 0);
   endtask

   initial begin
      av[0] = '{2'b00, 64'h1234, 64'hAAAA, 64'hBBBB, 5'd5, 1'b1, 64'h1234};
      av[1] = '{2'b10, 64'h1111, 64'h8000_0004, 64'h2222, 5'd1, 1'b1, 64'h8000_0004};
      av[2] = '{2'b11, 64'h3333, 64'h4444, 64'hFFFF_FFFF_DEAD_B000, 5'd31, 1'b1, 64'hFFFF_FFFF_DEAD_B000};
      av[3] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 5'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};

      //        st    addr        f3      wd                      rdata                   rdy rsp exp_wdata               wstrb  exp_res                 rw    mis   stl req
      mv[0]  = '{1'b0, 64'h1003, 3'b000, 64'h0,                  64'h0000_0000_8000_0000, 0, 0, 64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 2, 1};
      mv[1]  = '{1'b0, 64'h1003, 3'b100, 64'h0,                  64'h0000_0000_8000_0000, 0, 0, 64'h0,                  8'h00, 64'h0000_0000_0000_0080, 1'b1, 1'b0, 2, 1};
      mv[2]  = '{1'b0, 64'h1006, 3'b001, 64'h0,                  64'h8123_0000_0000_0000, 1, 1, 64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_8123, 1'b1, 1'b0, 4, 2};
      mv[3]  = '{1'b0, 64'h1006, 3'b101, 64'h0,                  64'h8123_0000_0000_0000, 0, 0, 64'h0,                  8'h00, 64'h0000_0000_0000_8123, 1'b1, 1'b0, 2, 1};
      mv[4]  = '{1'b0, 64'h1004, 3'b010, 64'h0,                  64'h9ABC_DEF0_0000_0000, 0, 2, 64'h0,                  8'h00, 64'hFFFF_FFFF_9ABC_DEF0, 1'b1, 1'b0, 4, 1};
      mv[5]  = '{1'b0, 64'h1004, 3'b110, 64'h0,                  64'h9ABC_DEF0_0000_0000, 0, 0, 64'h0,                  8'h00, 64'h0000_0000_9ABC_DEF0, 1'b1, 1'b0, 2, 1};
      mv[6]  = '{1'b0, 64'h1000, 3'b011, 64'h0,                  64'h0123_4567_89AB_CDEF, 2, 0, 64'h0,                  8'h00, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 4, 3};
      mv[7]  = '{1'b0, 64'h1008, 3'b111, 64'h0,                  64'h0123_4567_89AB_CDEF, 0, 0, 64'h0,                  8'h00, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 2, 1};
      mv[8]  = '{1'b0, 64'h1001, 3'b000, 64'h0,                  64'h0000_0000_0000_7F00, 0, 0, 64'h0,                  8'h00, 64'h0000_0000_0000_007F, 1'b1, 1'b0, 2, 1};
      mv[9]  = '{1'b1, 64'h2006, 3'b001, 64'hABCD,               64'h0,                   3, 0, 64'hABCD_ABCD_ABCD_ABCD, 8'hC0, 64'h0,                  1'b0, 1'b0, 4, 4};
      mv[10] = '{1'b1, 64'h2005, 3'b000, 64'h5A,                 64'h0,                   0, 0, 64'h5A5A_5A5A_5A5A_5A5A, 8'h20, 64'h0,                  1'b0, 1'b0, 1, 1};
      mv[11] = '{1'b1, 64'h2004, 3'b010, 64'h1111_2222_3333_4444, 64'h0,                  1, 0, 64'h3333_4444_3333_4444, 8'hF0, 64'h0,                  1'b0, 1'b0, 2, 2};
      mv[12] = '{1'b1, 64'h2000, 3'b011, 64'hFEDC_BA98_7654_3210, 64'h0,                  0, 0, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h0,                  1'b0, 1'b0, 1, 1};
      mv[13] = '{1'b0, 64'h3002, 3'b010, 64'h0,                  64'h0,                   0, 0, 64'h0,                  8'h00, 64'h0,                  1'b0, 1'b1, 1, 0};
      mv[14] = '{1'b1, 64'h3004, 3'b011, 64'h55,                 64'h0,                   0, 0, 64'h0,                  8'h00, 64'h0,                  1'b0, 1'b1, 1, 0};
      mv[15] = '{1'b0, 64'h3001, 3'b001, 64'h0,                  64'h0,                   0, 0, 64'h0,                  8'h00, 64'h0,                  1'b0, 1'b1, 1, 0};
      mv[16] = '{1'b0, 64'h3007, 3'b000, 64'h0,                  64'hC300_0000_0000_0000, 0, 0, 64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_FFC3, 1'b1, 1'b0, 2, 1};

      rst = 1'b0;
      dmem_rdata = '0;
      set_nop();
      #3;
      check("reset_result", ResultW, 0);
      check("reset_rd", RdW, 0);
      check("reset_regwrite", RegWriteW, 0);
      check("reset_misalign", MisalignW, 0);
      check("reset_req_valid", dmem_req_valid, 0);
      check("reset_stall", StallM, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < 4; i++) run_alu(i, av[i]);
      set_nop();
      @(posedge clk); #1;
      for (int i = 0; i < 17; i++) run_mem(i, mv[i]);

      // ADD, LD (response two cycles after accept), ADD: every write retires once, in order.
      log_en = 1'b1;
      ALUResultM = 64'h11; RdM = 5'd3; RegWriteM = 1'b1; ResultSrcM = 2'b00; MemWriteM = 1'b0; Funct3M = 3'b000;
      @(posedge clk); #1;
      ALUResultM = 64'h4000; RdM = 5'd7; ResultSrcM = 2'b01; Funct3M = 3'b011;
      dmem_rdata = 64'h0123_4567_89AB_CDEF; dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      check("b2b_wait_stall", StallM, 1);
      check("b2b_bubble_regwrite", RegWriteW, 0);
      check("b2b_bubble_hold_result", ResultW, 64'h11);
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      check("b2b_done_stall", StallM, 0);
      @(posedge clk); #1;
      ALUResultM = 64'h22; RdM = 5'd4; ResultSrcM = 2'b00; Funct3M = 3'b000;
      @(posedge clk); #1;
      set_nop();
      @(posedge clk); #1;
      @(posedge clk); #1;
      log_en = 1'b0;
      check("b2b_write_count", 64'(wn), 3);
      check("b2b_w0_result", wlog[0], 64'h11);
      check("b2b_w0_rd", wrd[0], 5'd3);
      check("b2b_w1_result", wlog[1], 64'h0123_4567_89AB_CDEF);
      check("b2b_w1_rd", wrd[1], 5'd7);
      check("b2b_w2_result", wlog[2], 64'h22);
      check("b2b_w2_rd", wrd[2], 5'd4);

      // Reset asserted while waiting for a load response, then a stray late response.
      ALUResultM = 64'h5000; RdM = 5'd9; RegWriteM = 1'b1; ResultSrcM = 2'b01; Funct3M = 3'b011;
      dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; dmem_req_ready = 1'b1;
      @(negedge clk);
      check("rstmid_req_before", dmem_req_valid, 1);
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      @(negedge clk);
      check("rstmid_waiting", StallM, 1);
      #1 rst = 1'b0;
      #1;
      check("rstmid_result", ResultW, 0);
      check("rstmid_rd", RdW, 0);
      check("rstmid_regwrite", RegWriteW, 0);
      check("rstmid_misalign", MisalignW, 0);
      check("rstmid_req_valid", dmem_req_valid, 0);
      check("rstmid_stall", StallM, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      set_nop();
      @(negedge clk);
      dmem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      check("late_rsp_regwrite", RegWriteW, 0);
      check("late_rsp_result", ResultW, 0);
      check("late_rsp_stall", StallM, 0);
      check("late_rsp_req_valid", dmem_req_valid, 0);
      @(posedge clk); #1;
      check("late_rsp_regwrite_next", RegWriteW, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the RV64 Zba core; consumes the EX/MEM register outputs (ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM, ExtImmM) plus Funct3M.
- Drives a valid/ready data-memory bus, formats loads (sign/zero extend) and stores (byte strobes), and stalls upstream while an access is outstanding.
- Selects the writeback result and registers it for the register file.

Parameters:
XLEN, 64, datapath width; only 64 supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ALUResultM  in  64  address or ALU result
WriteDataM  in  64  store data (rs2)
PCPlus4M  in  64  link value
ExtImmM  in  64  immediate (LUI path)
RdM  in  5  destination register
RegWriteM  in  1  writeback enable
MemWriteM  in  1  store
ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 ExtImm
Funct3M  in  3  access size/sign
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  request accepted
dmem_we  out  1  1 store, 0 load
dmem_addr  out  64  {ALUResultM[63:3],3'b000}
dmem_wdata  out  64  lane-replicated store data
dmem_wstrb  out  8  byte enables
dmem_rsp_valid  in  1  load data valid, one cycle
dmem_rdata  in  64  aligned doubleword
StallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM
ResultW  out  64  writeback value
RdW  out  5  writeback register
RegWriteW  out  1  writeback enable
MisalignW  out  1  misaligned-access flag, one cycle

Behaviour:
- Reset (rst=0, async): FSM=IDLE; ResultW=0, RdW=0, RegWriteW=0, MisalignW=0. Combinational outputs follow IDLE with no memory op.
- memop = MemWriteM | (ResultSrcM==01). Lane = ALUResultM[2:0].
- misaligned: size half & lane[0]!=0; size word & lane[1:0]!=0; size dword & lane!=0. Size comes from Funct3M[1:0].
- FSM states: IDLE, WAIT_RSP, DONE.
  - IDLE, no memop: StallM=0; W registers load at the edge; stay IDLE.
  - IDLE, memop & misaligned: no request; StallM=1; next state DONE; the DONE cycle writes RegWriteW=0, MisalignW=1.
  - IDLE, memop & aligned: dmem_req_valid=1, StallM=1.
    - ready & store -> DONE.
    - ready & load -> WAIT_RSP.
    - !ready -> stay IDLE with the request held stable.
  - WAIT_RSP: StallM=1, dmem_req_valid=0. On dmem_rsp_valid, capture the formatted load into the hold register and go to DONE.
  - DONE: StallM=0; W registers load; next state IDLE.
- While StallM=1, each edge writes a bubble: RegWriteW=0, MisalignW=0. ResultW and RdW hold.
- Minimum M-stage occupancy: non-memory op 1 cycle; store 2 cycles; load 3 cycles.
- Store formatting by Funct3M:
  - 000 SB: wdata = byte replicated x8; wstrb = 1<<lane.
  - 001 SH: halfword replicated x4; wstrb = 2'b11<<lane.
  - 010 SW: word x2; wstrb = 4'hF<<lane.
  - 011 SD: wstrb = FF.
- Load formatting: shifted = dmem_rdata >> (lane*8).
  - 000 LB: sext byte. 001 LH: sext half. 010 LW: sext word. 011 LD: full doubleword.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended.
  - 111: treated as LD.
- ResultW mux:
  - 00 -> ALUResultM; 01 -> load hold register; 10 -> PCPlus4M; 11 -> ExtImmM.
  - Stores write RegWriteW = RegWriteM (0 from decoder).
- dmem_rsp_valid in IDLE or DONE is ignored. Reset mid-transaction returns to IDLE and drops the request; a late response is ignored.
- A request, once valid, keeps addr/wdata/wstrb/we stable until accepted. Inputs are stable because StallM holds EX/MEM.

Test Plan:
- Reset: assert rst=0 mid-WAIT_RSP -> all W outputs 0, dmem_req_valid=0. A rsp_valid pulse after release -> ignored, RegWriteW stays 0.
- ALU op: ResultSrcM=00, ALUResultM=0x1234, RdM=5, RegWriteM=1 -> next edge ResultW=0x1234, RdW=5, RegWriteW=1; StallM never high.
- LB: addr=0x1003, dmem_rdata=0x00000000_80000000_ready immediate, byte lane3=0x80 (rdata=0x0000_0000_8000_0000 >> 24) -> ResultW=0xFFFF_FFFF_FFFF_FF80. With Funct3M=100 (LBU) -> ResultW=0x80. StallM high exactly 2 cycles.
- SH: addr=0x2006, WriteDataM=0xABCD, ready held low 3 cycles -> req_valid high 4 cycles, stable; wstrb=0xC0; wdata=0xABCD_ABCD_ABCD_ABCD; RegWriteW=0.
- LW misaligned: addr=0x3002, Funct3M=010 -> no request; MisalignW=1 for one cycle; RegWriteW=0.
- Back-to-back: ADD then LD (rdata=0x0123_4567_89AB_CDEF, rsp 2 cycles after accept) then ADD -> W sequence ADD, bubbles, LD result 0x0123_4567_89AB_CDEF, ADD; none dropped or duplicated.
